// File: rtl/baud_tick_generator_pkg.sv
// Shared constants and divisor helpers for the baud tick generator.
// The rate table maps the 3-bit selector to a tick rate in Hz.
package baud_tick_pkg;

  localparam int TICKS_W_DEFAULT = 17;
  localparam int PRESC_W_DEFAULT = 26;
  localparam int NUM_RATES       = 8;

  function automatic int unsigned rate_hz(input logic [2:0] sel);
    int unsigned r;
    case (sel)
      3'd0:    r = 9600;
      3'd1:    r = 19200;
      3'd2:    r = 38400;
      3'd3:    r = 57600;
      3'd4:    r = 115200;
      3'd5:    r = 1000;
      3'd6:    r = 100;
      default: r = 1;
    endcase
    return r;
  endfunction

  // A rate faster than the clock clamps to one tick per clock.
  function automatic int unsigned div_for(input logic [2:0] sel, input int unsigned clk_hz);
    int unsigned q;
    q = clk_hz / rate_hz(sel);
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/baud_tick_generator_if.sv
// Control/status bundle between a stepper consumer and the baud tick generator.
interface baud_tick_if
  import baud_tick_pkg::*;
#(
  parameter int TICKS_W = TICKS_W_DEFAULT
);
  logic               start;
  logic [2:0]         baud_rate_1;
  logic [TICKS_W-1:0] ticks;
  logic               tick;

  modport master (output start, baud_rate_1, input ticks, tick);
  modport slave  (input start, baud_rate_1, output ticks, tick);
endinterface

// File: rtl/baud_tick_generator_prescaler.sv
// Clock prescaler: counts 0..div-1 while enabled and flags the terminal cycle.
module tick_prescaler
  import baud_tick_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               expire
);

  logic [PRESC_W-1:0] count;
  logic               at_end;

  assign at_end = (count == div - PRESC_W'(1));
  assign expire = en & ~clr & at_end;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      count <= '0;
    end else if (at_end) begin
      count <= '0;
    end else begin
      count <= count + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// Free-running tick counter paced by a selectable-rate prescaler.
// A selector change restarts the period so no partial period is seen at the new rate.
module baud_tick_generator
  import baud_tick_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int          TICKS_W     = TICKS_W_DEFAULT,
  parameter int          PRESC_W     = PRESC_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  baud_tick_if.slave bus
);

  logic [2:0]         sel_q;
  logic               sel_changed;
  logic [TICKS_W-1:0] ticks_q;
  logic               tick_q;
  logic               expire;
  logic [PRESC_W-1:0] div;
  logic [PRESC_W-1:0] div_tbl [NUM_RATES];

  for (genvar g = 0; g < NUM_RATES; g++) begin : g_div
    assign div_tbl[g] = PRESC_W'(div_for(3'(g), CLK_FREQ_HZ));
  end

  assign div         = div_tbl[sel_q];
  assign sel_changed = (bus.baud_rate_1 != sel_q);

  tick_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.start),
    .clr    (sel_changed),
    .div    (div),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      ticks_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      sel_q  <= bus.baud_rate_1;
      tick_q <= expire;
      if (expire) begin
        ticks_q <= ticks_q + TICKS_W'(1);
      end
    end
  end

  assign bus.ticks = ticks_q;
  assign bus.tick  = tick_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator at CLK_FREQ_HZ=96000 (sel0 DIV=10, sel4 DIV=1, sel5 DIV=96).
module tb_baud_tick_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  baud_tick_if #(.TICKS_W(17)) bus ();

  baud_tick_generator #(
    .CLK_FREQ_HZ (96_000),
    .TICKS_W     (17),
    .PRESC_W     (26)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        start;
    logic [2:0]  sel;
    int          n;
    logic [16:0] exp_ticks;
    logic        exp_tick;
  } vec_t;

  vec_t vecs [23];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [16:0] exp_ticks, input logic exp_tick);
    checks++;
    if (bus.ticks !== exp_ticks) begin
      errors++;
      $display("FAIL %s ticks got %0h expected %0h", name, bus.ticks, exp_ticks);
    end
    checks++;
    if (bus.tick !== exp_tick) begin
      errors++;
      $display("FAIL %s tick got %0b expected %0b", name, bus.tick, exp_tick);
    end
  endtask

  task automatic drive_step_check(input string name, input logic st, input logic [2:0] sel,
                                  input int n, input logic [16:0] et, input logic ek);
    bus.start       = st;
    bus.baud_rate_1 = sel;
    step(n);
    check(name, et, ek);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 9,  17'd0,  1'b0};
    vecs[1]  = '{1'b1, 3'd0, 1,  17'd1,  1'b1};
    vecs[2]  = '{1'b1, 3'd0, 1,  17'd1,  1'b0};
    vecs[3]  = '{1'b1, 3'd0, 8,  17'd1,  1'b0};
    vecs[4]  = '{1'b1, 3'd0, 1,  17'd2,  1'b1};
    vecs[5]  = '{1'b1, 3'd0, 10, 17'd3,  1'b1};
    vecs[6]  = '{1'b1, 3'd0, 5,  17'd3,  1'b0};
    vecs[7]  = '{1'b0, 3'd0, 50, 17'd3,  1'b0};
    vecs[8]  = '{1'b1, 3'd0, 9,  17'd3,  1'b0};
    vecs[9]  = '{1'b1, 3'd0, 1,  17'd4,  1'b1};
    vecs[10] = '{1'b1, 3'd4, 1,  17'd4,  1'b0};
    vecs[11] = '{1'b1, 3'd4, 1,  17'd5,  1'b1};
    vecs[12] = '{1'b1, 3'd4, 5,  17'd10, 1'b1};
    vecs[13] = '{1'b1, 3'd0, 1,  17'd10, 1'b0};
    vecs[14] = '{1'b1, 3'd0, 9,  17'd10, 1'b0};
    vecs[15] = '{1'b1, 3'd0, 1,  17'd11, 1'b1};
    vecs[16] = '{1'b1, 3'd1, 5,  17'd11, 1'b0};
    vecs[17] = '{1'b1, 3'd1, 1,  17'd12, 1'b1};
    vecs[18] = '{1'b1, 3'd2, 2,  17'd12, 1'b0};
    vecs[19] = '{1'b1, 3'd2, 1,  17'd13, 1'b1};
    vecs[20] = '{1'b1, 3'd2, 2,  17'd14, 1'b1};
    vecs[21] = '{1'b1, 3'd3, 3,  17'd16, 1'b1};
    vecs[22] = '{1'b0, 3'd3, 2,  17'd16, 1'b0};

    bus.start       = 1'b0;
    bus.baud_rate_1 = 3'd0;
    rst             = 1'b1;
    @(negedge clk);
    step(3);
    rst = 1'b0;
    check("reset", 17'd0, 1'b0);

    for (int i = 0; i < 23; i++) begin
      drive_step_check($sformatf("vec%0d", i), vecs[i].start, vecs[i].sel, vecs[i].n,
                       vecs[i].exp_ticks, vecs[i].exp_tick);
    end

    // Selector switch on the terminal prescaler count of the slow rate.
    drive_step_check("sel5_change", 1'b1, 3'd5, 1,  17'd16, 1'b0);
    drive_step_check("sel5_p95",    1'b1, 3'd5, 95, 17'd16, 1'b0);
    drive_step_check("switch_wins", 1'b1, 3'd0, 1,  17'd16, 1'b0);
    drive_step_check("switch_wait", 1'b1, 3'd0, 9,  17'd16, 1'b0);
    drive_step_check("switch_inc",  1'b1, 3'd0, 1,  17'd17, 1'b1);

    // Wrap-around from a preloaded count.
    drive_step_check("pre_wrap_idle", 1'b0, 3'd0, 1, 17'd17, 1'b0);
    force dut.ticks_q = 17'h1FFFD;
    #1;
    release dut.ticks_q;
    check("preload", 17'h1FFFD, 1'b0);
    drive_step_check("wrap_sel4",  1'b1, 3'd4, 1, 17'h1FFFD, 1'b0);
    drive_step_check("wrap_1fffe", 1'b1, 3'd4, 1, 17'h1FFFE, 1'b1);
    drive_step_check("wrap_1ffff", 1'b1, 3'd4, 1, 17'h1FFFF, 1'b1);
    drive_step_check("wrap_zero",  1'b1, 3'd4, 1, 17'h00000, 1'b1);
    drive_step_check("wrap_one",   1'b1, 3'd4, 1, 17'h00001, 1'b1);

    // Reset in the middle of a period.
    drive_step_check("rst_pre_chg", 1'b1, 3'd0, 1,  17'd1, 1'b0);
    drive_step_check("rst_pre_9",   1'b1, 3'd0, 9,  17'd1, 1'b0);
    drive_step_check("rst_pre_inc", 1'b1, 3'd0, 1,  17'd2, 1'b1);
    drive_step_check("rst_pre_mid", 1'b1, 3'd0, 4,  17'd2, 1'b0);
    rst = 1'b1;
    step(1);
    check("rst_mid", 17'd0, 1'b0);
    rst = 1'b0;
    drive_step_check("rst_post_9",   1'b1, 3'd0, 9, 17'd0, 1'b0);
    drive_step_check("rst_post_inc", 1'b1, 3'd0, 1, 17'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
